// File: rtl/c499d_pkg.sv
// Shared constants and syndrome function for the c499-style 32-bit SEC decoder.
// No latency or backpressure: constants and pure combinational helpers only.
package c499d_pkg;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int CW  = 8;

    localparam logic [3:0] LOW [0:7] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    // Column k = {one-hot(k/8), LOW[k%8]}; every column has weight 2 or 4.
    localparam logic [CW-1:0] COL [0:DW-1] = '{
        8'h11, 8'h12, 8'h14, 8'h18, 8'h17, 8'h1B, 8'h1D, 8'h1E,
        8'h21, 8'h22, 8'h24, 8'h28, 8'h27, 8'h2B, 8'h2D, 8'h2E,
        8'h41, 8'h42, 8'h44, 8'h48, 8'h47, 8'h4B, 8'h4D, 8'h4E,
        8'h81, 8'h82, 8'h84, 8'h88, 8'h87, 8'h8B, 8'h8D, 8'h8E
    };

    function automatic logic [CW-1:0] calc_syndrome(
        input logic [DW-1:0] d,
        input logic [CW-1:0] c,
        input logic          r
    );
        logic [CW-1:0] s;
        s = c & {CW{r}};
        for (int k = 0; k < DW; k++) begin
            s = s ^ (COL[k] & {CW{d[k]}});
        end
        return s;
    endfunction

endpackage

// File: rtl/c499d_sec_core.sv
// Single-channel combinational SEC decoder: syndrome, then flip the matching data bit.
// Zero latency, no backpressure; non-matching syndromes pass data through unchanged.
module c499d_sec_core
    import c499d_pkg::*;
(
    input  logic [DW-1:0] i_d,
    input  logic [CW-1:0] i_c,
    input  logic          i_r,
    output logic [DW-1:0] o_q,
    output logic [CW-1:0] o_s
);

    logic [CW-1:0] w_s;

    assign w_s = calc_syndrome(i_d, i_c, i_r);
    assign o_s = w_s;

    // Columns are distinct, so at most one bit can match.
    always_comb begin
        o_q = i_d;
        for (int k = 0; k < DW; k++) begin
            o_q[k] = i_d[k] ^ (w_s == COL[k]);
        end
    end

endmodule

// File: rtl/c499d_sec_dual.sv
// Two independent c499-style SEC channels with one output register stage (1-cycle latency, no backpressure).
// Define C499D_ERR_FLAG_EN to add registered err1/err2 (nonzero-syndrome) outputs.
module c499d_sec_dual
    import c499d_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef C499D_ERR_FLAG_EN
    output logic err1,
    output logic err2,
`endif
    input  logic N11, N15, N19, N113, N117, N121, N125, N129,
                 N133, N137, N141, N145, N149, N153, N157, N161,
                 N165, N169, N173, N177, N181, N185, N189, N193,
                 N197, N1101, N1105, N1109, N1113, N1117, N1121, N1125,
    input  logic N1129, N1130, N1131, N1132, N1133, N1134, N1135, N1136,
    input  logic N1137,
    input  logic N21, N25, N29, N213, N217, N221, N225, N229,
                 N233, N237, N241, N245, N249, N253, N257, N261,
                 N265, N269, N273, N277, N281, N285, N289, N293,
                 N297, N2101, N2105, N2109, N2113, N2117, N2121, N2125,
    input  logic N2129, N2130, N2131, N2132, N2133, N2134, N2135, N2136,
    input  logic N2137,
    output logic N1724, N1725, N1726, N1727, N1728, N1729, N1730, N1731,
                 N1732, N1733, N1734, N1735, N1736, N1737, N1738, N1739,
                 N1740, N1741, N1742, N1743, N1744, N1745, N1746, N1747,
                 N1748, N1749, N1750, N1751, N1752, N1753, N1754, N1755,
    output logic N2724, N2725, N2726, N2727, N2728, N2729, N2730, N2731,
                 N2732, N2733, N2734, N2735, N2736, N2737, N2738, N2739,
                 N2740, N2741, N2742, N2743, N2744, N2745, N2746, N2747,
                 N2748, N2749, N2750, N2751, N2752, N2753, N2754, N2755
);

    logic [DW-1:0] w_d1, w_d2, w_q1, w_q2;
    logic [CW-1:0] w_c1, w_c2, w_s1, w_s2;
    logic [DW-1:0] r_q1, r_q2;

    // Data pin N<ch>(1+4k) carries bit k.
    assign w_d1 = {N1125, N1121, N1117, N1113, N1109, N1105, N1101, N197,
                   N193,  N189,  N185,  N181,  N177,  N173,  N169,  N165,
                   N161,  N157,  N153,  N149,  N145,  N141,  N137,  N133,
                   N129,  N125,  N121,  N117,  N113,  N19,   N15,   N11};
    assign w_d2 = {N2125, N2121, N2117, N2113, N2109, N2105, N2101, N297,
                   N293,  N289,  N285,  N281,  N277,  N273,  N269,  N265,
                   N261,  N257,  N253,  N249,  N245,  N241,  N237,  N233,
                   N229,  N225,  N221,  N217,  N213,  N29,   N25,   N21};
    assign w_c1 = {N1136, N1135, N1134, N1133, N1132, N1131, N1130, N1129};
    assign w_c2 = {N2136, N2135, N2134, N2133, N2132, N2131, N2130, N2129};

    c499d_sec_core u_ch1 (
        .i_d (w_d1),
        .i_c (w_c1),
        .i_r (N1137),
        .o_q (w_q1),
        .o_s (w_s1)
    );

    c499d_sec_core u_ch2 (
        .i_d (w_d2),
        .i_c (w_c2),
        .i_r (N2137),
        .o_q (w_q2),
        .o_s (w_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= w_q1;
            r_q2 <= w_q2;
        end
    end

`ifdef C499D_ERR_FLAG_EN
    logic r_err1, r_err2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err1 <= 1'b0;
            r_err2 <= 1'b0;
        end else begin
            r_err1 <= |w_s1;
            r_err2 <= |w_s2;
        end
    end

    assign err1 = r_err1;
    assign err2 = r_err2;
`else
    logic w_syn_unused;
    assign w_syn_unused = ^{w_s1, w_s2};
`endif

    assign {N1755, N1754, N1753, N1752, N1751, N1750, N1749, N1748,
            N1747, N1746, N1745, N1744, N1743, N1742, N1741, N1740,
            N1739, N1738, N1737, N1736, N1735, N1734, N1733, N1732,
            N1731, N1730, N1729, N1728, N1727, N1726, N1725, N1724} = r_q1;
    assign {N2755, N2754, N2753, N2752, N2751, N2750, N2749, N2748,
            N2747, N2746, N2745, N2744, N2743, N2742, N2741, N2740,
            N2739, N2738, N2737, N2736, N2735, N2734, N2733, N2732,
            N2731, N2730, N2729, N2728, N2727, N2726, N2725, N2724} = r_q2;

endmodule

// File: tb/tb_c499d_sec_dual.sv
// Directed self-checking bench for the dual c499-style SEC decoder.
module tb_c499d_sec_dual;

    logic        clk;
    logic        rst;
    logic [31:0] d1, d2;
    logic [7:0]  c1, c2;
    logic        r1, r2;
    wire  [31:0] q1, q2;
`ifdef C499D_ERR_FLAG_EN
    wire         err1, err2;
`endif

    int errors = 0;
    int checks = 0;

    c499d_sec_dual dut (
        .clk(clk), .rst(rst),
`ifdef C499D_ERR_FLAG_EN
        .err1(err1), .err2(err2),
`endif
        .N11(d1[0]), .N15(d1[1]), .N19(d1[2]), .N113(d1[3]), .N117(d1[4]), .N121(d1[5]),
        .N125(d1[6]), .N129(d1[7]), .N133(d1[8]), .N137(d1[9]), .N141(d1[10]), .N145(d1[11]),
        .N149(d1[12]), .N153(d1[13]), .N157(d1[14]), .N161(d1[15]), .N165(d1[16]), .N169(d1[17]),
        .N173(d1[18]), .N177(d1[19]), .N181(d1[20]), .N185(d1[21]), .N189(d1[22]), .N193(d1[23]),
        .N197(d1[24]), .N1101(d1[25]), .N1105(d1[26]), .N1109(d1[27]), .N1113(d1[28]),
        .N1117(d1[29]), .N1121(d1[30]), .N1125(d1[31]),
        .N1129(c1[0]), .N1130(c1[1]), .N1131(c1[2]), .N1132(c1[3]),
        .N1133(c1[4]), .N1134(c1[5]), .N1135(c1[6]), .N1136(c1[7]), .N1137(r1),
        .N21(d2[0]), .N25(d2[1]), .N29(d2[2]), .N213(d2[3]), .N217(d2[4]), .N221(d2[5]),
        .N225(d2[6]), .N229(d2[7]), .N233(d2[8]), .N237(d2[9]), .N241(d2[10]), .N245(d2[11]),
        .N249(d2[12]), .N253(d2[13]), .N257(d2[14]), .N261(d2[15]), .N265(d2[16]), .N269(d2[17]),
        .N273(d2[18]), .N277(d2[19]), .N281(d2[20]), .N285(d2[21]), .N289(d2[22]), .N293(d2[23]),
        .N297(d2[24]), .N2101(d2[25]), .N2105(d2[26]), .N2109(d2[27]), .N2113(d2[28]),
        .N2117(d2[29]), .N2121(d2[30]), .N2125(d2[31]),
        .N2129(c2[0]), .N2130(c2[1]), .N2131(c2[2]), .N2132(c2[3]),
        .N2133(c2[4]), .N2134(c2[5]), .N2135(c2[6]), .N2136(c2[7]), .N2137(r2),
        .N1724(q1[0]), .N1725(q1[1]), .N1726(q1[2]), .N1727(q1[3]), .N1728(q1[4]),
        .N1729(q1[5]), .N1730(q1[6]), .N1731(q1[7]), .N1732(q1[8]), .N1733(q1[9]),
        .N1734(q1[10]), .N1735(q1[11]), .N1736(q1[12]), .N1737(q1[13]), .N1738(q1[14]),
        .N1739(q1[15]), .N1740(q1[16]), .N1741(q1[17]), .N1742(q1[18]), .N1743(q1[19]),
        .N1744(q1[20]), .N1745(q1[21]), .N1746(q1[22]), .N1747(q1[23]), .N1748(q1[24]),
        .N1749(q1[25]), .N1750(q1[26]), .N1751(q1[27]), .N1752(q1[28]), .N1753(q1[29]),
        .N1754(q1[30]), .N1755(q1[31]),
        .N2724(q2[0]), .N2725(q2[1]), .N2726(q2[2]), .N2727(q2[3]), .N2728(q2[4]),
        .N2729(q2[5]), .N2730(q2[6]), .N2731(q2[7]), .N2732(q2[8]), .N2733(q2[9]),
        .N2734(q2[10]), .N2735(q2[11]), .N2736(q2[12]), .N2737(q2[13]), .N2738(q2[14]),
        .N2739(q2[15]), .N2740(q2[16]), .N2741(q2[17]), .N2742(q2[18]), .N2743(q2[19]),
        .N2744(q2[20]), .N2745(q2[21]), .N2746(q2[22]), .N2747(q2[23]), .N2748(q2[24]),
        .N2749(q2[25]), .N2750(q2[26]), .N2751(q2[27]), .N2752(q2[28]), .N2753(q2[29]),
        .N2754(q2[30]), .N2755(q2[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder built straight from the column definition.
    function automatic logic [7:0] tb_col(input int k);
        logic [3:0] hi, lo;
        hi = 4'b0001 << (k / 8);
        case (k % 8)
            0: lo = 4'b0001;  1: lo = 4'b0010;  2: lo = 4'b0100;  3: lo = 4'b1000;
            4: lo = 4'b0111;  5: lo = 4'b1011;  6: lo = 4'b1101;  default: lo = 4'b1110;
        endcase
        return {hi, lo};
    endfunction

    function automatic logic [7:0] tb_enc(input logic [31:0] w);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < 32; k++) if (w[k]) s = s ^ tb_col(k);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d1 = $urandom; d2 = $urandom; c1 = 8'($urandom); c2 = 8'($urandom);
            r1 = 1'($urandom); r2 = 1'($urandom);
            step();
            checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL reset_q1 cyc%0d got=%h exp=00000000", i, q1); end
            checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL reset_q2 cyc%0d got=%h exp=00000000", i, q2); end
`ifdef C499D_ERR_FLAG_EN
            checks++; if ({err1, err2} !== 2'b00) begin errors++; $display("FAIL reset_err cyc%0d got=%b exp=00", i, {err1, err2}); end
`endif
        end
        rst = 1'b0;
        d1 = 32'hA5A5A5A5; c1 = tb_enc(32'hA5A5A5A5); r1 = 1'b1;
        d2 = 32'h0F0F0F0F; c2 = tb_enc(32'h0F0F0F0F); r2 = 1'b1;
        #2;
        checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL release_hold got=%h exp=00000000", q1); end
        step();
        checks++; if (q1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL release_q1 got=%h exp=a5a5a5a5", q1); end
        checks++; if (q2 !== 32'h0F0F0F0F) begin errors++; $display("FAIL release_q2 got=%h exp=0f0f0f0f", q2); end
        rst = 1'b1;
        step();
        checks++; if ({q1, q2} !== 64'h0) begin errors++; $display("FAIL midreset got=%h exp=0", {q1, q2}); end
        rst = 1'b0;
        step();
        checks++; if (q1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL postreset_q1 got=%h exp=a5a5a5a5", q1); end
    endtask

    task automatic test_independence();
        d1 = 32'h00000001; c1 = 8'h00; r1 = 1'b1;
        d2 = 32'h00000001; c2 = 8'h11; r2 = 1'b1;
        step();
        checks++; if (q1 !== 32'h00000000) begin errors++; $display("FAIL indep_q1 got=%h exp=00000000", q1); end
        checks++; if (q2 !== 32'h00000001) begin errors++; $display("FAIL indep_q2 got=%h exp=00000001", q2); end
`ifdef C499D_ERR_FLAG_EN
        checks++; if ({err1, err2} !== 2'b10) begin errors++; $display("FAIL indep_err got=%b exp=10", {err1, err2}); end
`endif
    endtask

    task automatic test_top_bit();
        d1 = 32'h80000000; c1 = 8'h00; r1 = 1'b1;
        d2 = 32'h80000000; c2 = 8'hFF; r2 = 1'b0;
        step();
        checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL top_r1 got=%h exp=00000000", q1); end
        checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL top_r0 got=%h exp=00000000", q2); end
        d1 = 32'h00000000; c1 = 8'h11; r1 = 1'b1;
        d2 = 32'h00000000; c2 = 8'h11; r2 = 1'b0;
        step();
        checks++; if (q1 !== 32'h00000001) begin errors++; $display("FAIL renable_on got=%h exp=00000001", q1); end
        checks++; if (q2 !== 32'h00000000) begin errors++; $display("FAIL renable_off got=%h exp=00000000", q2); end
    endtask

    task automatic test_no_column();
        d1 = 32'h00000000; c1 = 8'h01; r1 = 1'b1;
        d2 = 32'h00000003; c2 = 8'h00; r2 = 1'b1;
        step();
        checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL checkbit_err got=%h exp=00000000", q1); end
        checks++; if (q2 !== 32'h00000003) begin errors++; $display("FAIL nocol got=%h exp=00000003", q2); end
`ifdef C499D_ERR_FLAG_EN
        checks++; if ({err1, err2} !== 2'b11) begin errors++; $display("FAIL nocol_err got=%b exp=11", {err1, err2}); end
`endif
    endtask

    task automatic test_sweep();
        logic [31:0] wa, wb, w1, w2, prev1, prev2;
        wa = 32'h12345678; wb = 32'hDEADBEEF;
        d1 = wb; c1 = tb_enc(wb); r1 = 1'b1;
        d2 = wa; c2 = tb_enc(wa); r2 = 1'b1;
        step();
        prev1 = wb; prev2 = wa;
        for (int k = 0; k < 32; k++) begin
            w1 = (k % 2 == 0) ? wa : wb;
            w2 = (k % 2 == 0) ? wb : wa;
            d1 = w1 ^ (32'h1 << k);        c1 = tb_enc(w1);
            d2 = w2 ^ (32'h1 << (31 - k)); c2 = tb_enc(w2);
            #2;
            checks++; if (q1 !== prev1) begin errors++; $display("FAIL sweep_hold bit%0d got=%h exp=%h", k, q1, prev1); end
            step();
            checks++; if (q1 !== w1) begin errors++; $display("FAIL sweep_q1 bit%0d got=%h exp=%h", k, q1, w1); end
            checks++; if (q2 !== w2) begin errors++; $display("FAIL sweep_q2 bit%0d got=%h exp=%h", 31 - k, q2, w2); end
`ifdef C499D_ERR_FLAG_EN
            checks++; if ({err1, err2} !== 2'b11) begin errors++; $display("FAIL sweep_err bit%0d got=%b exp=11", k, {err1, err2}); end
`endif
            prev1 = w1; prev2 = w2;
        end
    endtask

    initial begin
        rst = 1'b1;
        d1 = '0; d2 = '0; c1 = '0; c2 = '0; r1 = 1'b0; r2 = 1'b0;
        #2;
        test_reset();
        test_independence();
        test_top_bit();
        test_no_column();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c499d_sec_dual.md
Name: c499d_sec_dual

Overview:
- Dual-channel 32-bit single-error-correcting (SEC) decoder, modelled on the ISCAS-85 c499 function and instantiated twice (channel 1 and channel 2).
- Each channel takes 32 data bits, 8 check bits and an enable R, computes an 8-bit syndrome and flips the single data bit whose code column matches it.
- Used as an aging and stress workload block.
- The datapath is combinational, followed by one output register stage.

Parameters:
- NCH, 2, number of identical channels; fixed at 2.
- DW, 32, data bits per channel.
- CW, 8, check bits per channel.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- N11,N15,...,N1125  input  1 each  channel-1 data d1[k], k=0..31; port N1(1+4k) carries d1[k].
- N1129..N1136  input  1 each  channel-1 check bits c1[j], j=0..7; N1(129+j) carries c1[j].
- N1137  input  1  channel-1 check enable R1.
- N21..N2125, N2129..N2136, N2137  input  1 each  channel-2 equivalents: d2, c2, R2.
- N1724..N1755  output  1 each  channel-1 corrected data q1[k]; N1(724+k) carries q1[k].
- N2724..N2755  output  1 each  channel-2 corrected data q2[k].

Behaviour:
- Both channels are identical and fully independent.
- Code columns: data bit k = 8a+b, with a=0..3 and b=0..7.
  - col[k][7:4] = one-hot(a).
  - col[k][3:0] = LOW[b], where LOW = {0001, 0010, 0100, 1000, 0111, 1011, 1101, 1110}.
  - Examples: col[0]=0x11, col[7]=0x1E, col[8]=0x21, col[31]=0x8E.
  - All 32 columns are distinct and have weight 2 or 4. The check-bit columns are one-hot (weight 1).
- Syndrome: S[j] = (XOR of d[k] over all k with col[k][j]=1) XOR (c[j] AND R).
- Correction: qn[k] = d[k] XOR (S == col[k]). At most one bit flips per channel.
- Syndromes that match no column (zero, one-hot, or any unused pattern) leave the data unchanged.
- R=0 ignores the check bits; the syndrome is then pure data parity.
- Timing:
  - Inputs are sampled on a rising clk edge.
  - Outputs q register qn on that edge, giving 1-cycle latency.
  - Outputs hold their value between edges.
- Reset:
  - rst=1 at a rising edge clears all 64 outputs to 0. Reset has priority over new data.
  - The first edge with rst=0 loads the corrected data.
  - Reset asserted mid-stream clears outputs on that edge, with no residual state.
- There is no other state, no handshake, and no X-propagation requirement beyond normal 4-state simulation.

Optional Feature:
- Macro: C499D_ERR_FLAG_EN.
- With the macro:
  - Adds outputs err1 and err2 (1 bit each), registered alongside q and cleared by rst.
  - errN=1 when channel N's syndrome is nonzero.
- Without the macro: these ports and their logic are absent, and the rest of the block is unchanged.

Decomposition:
- Package c499d_pkg holds:
  - DW and CW.
  - LOW[0:7] constant.
  - COL[0:31] constant array of 8-bit columns.
  - A function that computes the syndrome from (d, c, R).
- One sub-module, c499d_sec_core: a combinational single-channel decoder (d, c, R -> q, S), instantiated twice.
- The top-level module holds the registers and reset.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> all q=0 (and err=0 when C499D_ERR_FLAG_EN is defined); release -> q follows after 1 edge.
2. Ch1 d=0x00000001, c=0x00, R=1 -> S=0x11 -> q1=0x00000000. Simultaneously ch2 d=0x00000001, c=0x11, R=1 -> S=0 -> q2=0x00000001 (channel independence).
3. d=0x80000000, c=0x00, R=1 -> S=0x8E -> q=0; same d with R=0 and c=0xFF -> S=0x8E -> q=0 (check bits ignored).
4. d=0, c=0x01, R=1 -> S=0x01 (check-bit error) -> q=0, data untouched. d=0x00000003, c=0, R=1 -> S=0x11^0x12=0x03 (no column) -> q=0x00000003.
5. Sweep all 32 single-bit data errors, with c set to the correct encoding of a random word and R=1 -> q equals the original word every cycle; also check the 1-cycle latency against the input stream.
